ad_capture_trig: RTL and testbench

AD_CAPTURE_TRIG -- requirements
Module: ad_capture_trig

---
 rtl/ad_capture_trig.sv | 222 ++++++++++++++++++++++
 tb/tb_ad_capture_trig.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_capture_trig.sv
`default_nettype none
// ============================================================================
// Module   : ad_capture_trig
// Brief    : Multi-channel ADC capture into a ring buffer with pre-trigger
//            history, edge/forced trigger and a valid/ready readout stream.
// Revision : 1.0
// ============================================================================
module ad_capture_trig #(
    parameter int CH_NUM = 2,
    parameter int AD_W   = 12,
    parameter int ADDR_W = 10,
    parameter int DIV_W  = 16
) (
    input  logic                                          clk50m,
    input  logic                                          reset_n,
    input  logic [CH_NUM*AD_W-1:0]                        ad_in,
    input  logic [DIV_W-1:0]                              div,
    input  logic                                          arm,
    input  logic                                          force_trig,
    input  logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] trig_ch,
    input  logic [AD_W-1:0]                               trig_level,
    input  logic                                          trig_edge,
    input  logic [ADDR_W-1:0]                             pretrig,
    output logic                                          busy,
    output logic                                          triggered,
    output logic                                          done,
    output logic [CH_NUM*AD_W-1:0]                        rd_data,
    output logic                                          rd_valid,
    input  logic                                          rd_ready,
    output logic                                          rd_last
);

    localparam int                c_TCH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int                c_DW      = CH_NUM * AD_W;
    localparam int                c_DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_PTR_MAX = ADDR_W'(c_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q;
    logic [c_DW-1:0]      ad_q;
    logic [DIV_W-1:0]     div_cnt_q;
    logic [ADDR_W-1:0]    wp_q;
    logic [ADDR_W-1:0]    rp_q;
    logic [ADDR_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]    rd_cnt_q;
    logic [c_TCH_W-1:0]   trig_ch_q;
    logic [AD_W-1:0]      lvl_q;
    logic                 edge_q;
    logic [ADDR_W-1:0]    pre_q;
    logic [AD_W-1:0]      prev_q;
    logic                 prev_vld_q;
    logic                 busy_q;
    logic                 trig_q;
    logic                 done_q;
    logic                 rd_valid_q;
    logic                 rd_last_q;
    logic [c_DW-1:0]      rd_data_q;
    logic [c_DW-1:0]      mem_q [c_DEPTH];

    logic                 w_strobe;
    logic                 w_we;
    logic [AD_W-1:0]      w_cur;
    logic                 w_level_hit;
    logic                 w_hit;
    logic [ADDR_W-1:0]    w_post_len;
    logic [ADDR_W-1:0]    w_pre_clamp;

    assign w_strobe    = (div_cnt_q == div);
    assign w_we        = w_strobe && busy_q;
    assign w_post_len  = c_PTR_MAX - pre_q;
    assign w_pre_clamp = (pretrig >= c_PTR_MAX) ? c_PTR_MAX : pretrig;

    always_comb begin
        w_cur = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (trig_ch_q == c_TCH_W'(k)) begin
                w_cur = ad_q[k*AD_W +: AD_W];
            end
        end
    end

    // The very first strobe after arm has no predecessor, so it cannot fire a level trigger.
    assign w_level_hit = prev_vld_q &&
                         (edge_q ? ((prev_q >= lvl_q) && (w_cur <  lvl_q))
                                 : ((prev_q <  lvl_q) && (w_cur >= lvl_q)));
    assign w_hit       = w_level_hit || force_trig;

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            ad_q      <= '0;
            div_cnt_q <= '0;
        end else begin
            ad_q      <= ad_in;
            div_cnt_q <= w_strobe ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk50m) begin
        if (w_we) begin
            mem_q[wp_q] <= ad_q;
        end
    end

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            rd_cnt_q   <= '0;
            trig_ch_q  <= '0;
            lvl_q      <= '0;
            edge_q     <= 1'b0;
            pre_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            trig_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else if (arm && (state_q == S_IDLE || state_q == S_DONE)) begin
            trig_ch_q  <= trig_ch;
            lvl_q      <= trig_level;
            edge_q     <= trig_edge;
            pre_q      <= w_pre_clamp;
            wp_q       <= '0;
            cnt_q      <= '0;
            prev_vld_q <= 1'b0;
            busy_q     <= 1'b1;
            trig_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            state_q    <= (w_pre_clamp != '0) ? S_PRE : S_WAIT;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_PRE: begin
                    if (w_strobe) begin
                        wp_q       <= wp_q + ADDR_W'(1);
                        prev_q     <= w_cur;
                        prev_vld_q <= 1'b1;
                        if (cnt_q + ADDR_W'(1) == pre_q) begin
                            cnt_q   <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (w_strobe) begin
                        wp_q       <= wp_q + ADDR_W'(1);
                        prev_q     <= w_cur;
                        prev_vld_q <= 1'b1;
                        if (w_hit) begin
                            trig_q <= 1'b1;
                            rp_q   <= wp_q - pre_q;
                            cnt_q  <= '0;
                            if (w_post_len == '0) begin
                                state_q  <= S_DONE;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                rd_cnt_q <= '0;
                            end else begin
                                state_q <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (w_strobe) begin
                        wp_q <= wp_q + ADDR_W'(1);
                        if (cnt_q + ADDR_W'(1) == w_post_len) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            rd_cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (rd_valid_q && rd_ready && rd_last_q) begin
                        state_q    <= S_IDLE;
                        done_q     <= 1'b0;
                        trig_q     <= 1'b0;
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                    end else if ((!rd_valid_q || rd_ready) && !rd_last_q) begin
                        // Refill the output register whenever it is empty or being consumed.
                        rd_data_q  <= mem_q[rp_q];
                        rd_valid_q <= 1'b1;
                        rd_last_q  <= (rd_cnt_q == c_PTR_MAX);
                        rp_q       <= rp_q + ADDR_W'(1);
                        rd_cnt_q   <= rd_cnt_q + ADDR_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign triggered = trig_q;
    assign done      = done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign rd_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ad_capture_trig.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad_capture_trig
// Brief    : Directed + randomized bench for ad_capture_trig (DEPTH = 16),
//            checked against a sample-history reference model.
// Revision : 1.0
// ============================================================================
module tb_ad_capture_trig;

    localparam int CH_NUM = 2;
    localparam int AD_W   = 12;
    localparam int ADDR_W = 4;
    localparam int DIV_W  = 16;
    localparam int DEPTH  = 16;

    logic              clk50m = 1'b0;
    logic              reset_n;
    logic [23:0]       ad_in;
    logic [15:0]       div;
    logic              arm;
    logic              force_trig;
    logic [0:0]        trig_ch;
    logic [11:0]       trig_level;
    logic              trig_edge;
    logic [3:0]        pretrig;
    logic              busy;
    logic              triggered;
    logic              done;
    logic [23:0]       rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_last;

    ad_capture_trig #(
        .CH_NUM (CH_NUM),
        .AD_W   (AD_W),
        .ADDR_W (ADDR_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk50m     (clk50m),
        .reset_n    (reset_n),
        .ad_in      (ad_in),
        .div        (div),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_ch    (trig_ch),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .pretrig    (pretrig),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_last    (rd_last)
    );

    always #5 clk50m = ~clk50m;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: every strobed sample since arm is kept in order; the
    // readout is simply the DEPTH-sample window placed around the trigger.
    int          mcnt;
    logic [23:0] m_adq;
    bit          m_cap;
    bit          m_done;
    int          m_trig;
    int          m_pre;
    int          m_ch;
    logic [11:0] m_lvl;
    bit          m_edge;
    logic [23:0] samp [$];
    logic [23:0] exp_q [DEPTH];
    logic [23:0] got [DEPTH];
    int          m_k;
    int          done_age;

    int          ad_mode;
    logic [11:0] ch0_v, ch1_v, ramp_v, d;
    int          n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] ch_of(input logic [23:0] s, input int ch);
        return (ch == 1) ? s[23:12] : s[11:0];
    endfunction

    task automatic model_clear();
        mcnt   = 0;
        m_adq  = '0;
        m_cap  = 0;
        m_done = 0;
        m_trig = -1;
        m_k    = 0;
    endtask

    task automatic tick();
        logic        pv, pl;
        logic [23:0] pd, smp;
        logic [11:0] cur, prv;
        bit          stb, hit;
        int          idx;
        case (ad_mode)
            0:       ad_in = {ch1_v, ch0_v};
            1:       begin ad_in = {ch1_v, ramp_v}; ramp_v = ramp_v + 12'd1; end
            2:       ad_in = 24'($urandom);
            default: begin ad_in = {ramp_v, ch0_v}; ramp_v = ramp_v + 12'd1; end
        endcase
        pv = rd_valid;
        pl = rd_last;
        pd = rd_data;
        @(posedge clk50m);
        #1;
        stb   = (mcnt == int'(div));
        smp   = m_adq;
        mcnt  = stb ? 0 : mcnt + 1;
        m_adq = ad_in;
        if (m_cap) begin
            if (stb) begin
                samp.push_back(smp);
                idx = samp.size() - 1;
                if (m_trig < 0 && idx >= m_pre) begin
                    cur = ch_of(smp, m_ch);
                    prv = (idx > 0) ? ch_of(samp[idx-1], m_ch) : 12'h0;
                    hit = force_trig || ((idx > 0) &&
                          (m_edge ? (prv >= m_lvl && cur < m_lvl) : (prv < m_lvl && cur >= m_lvl)));
                    if (hit) m_trig = idx;
                end
                if (m_trig >= 0 && idx == m_trig + DEPTH - 1 - m_pre) begin
                    for (int k = 0; k < DEPTH; k++) exp_q[k] = samp[m_trig - m_pre + k];
                    m_cap    = 0;
                    m_done   = 1;
                    m_k      = 0;
                    done_age = 0;
                end
            end
        end else if (arm) begin
            m_pre  = (int'(pretrig) >= DEPTH - 1) ? DEPTH - 1 : int'(pretrig);
            m_ch   = int'(trig_ch);
            m_lvl  = trig_level;
            m_edge = trig_edge;
            samp.delete();
            m_trig = -1;
            m_cap  = 1;
            m_done = 0;
        end else if (m_done) begin
            done_age++;
            if (pv && rd_ready) begin
                chk("rd_data", pd, exp_q[m_k]);
                chk("rd_last", pl, m_k == DEPTH - 1);
                got[m_k] = pd;
                m_k++;
                if (m_k == DEPTH) begin
                    m_done = 0;
                    m_trig = -1;
                end
            end else if (pv) begin
                chk("stall_data", rd_data, pd);
                chk("stall_valid", rd_valid, 1);
                chk("stall_last", rd_last, pl);
            end
        end
        chk("busy", busy, m_cap);
        chk("triggered", triggered, m_trig >= 0);
        chk("done", done, m_done);
        if (!m_done) chk("rd_valid_outside_done", rd_valid, 0);
        if (m_done && done_age >= 2) chk("rd_valid_in_done", rd_valid, 1);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        model_clear();
        @(negedge clk50m);
        @(negedge clk50m);
        reset_n = 1'b1;
    endtask

    task automatic run_done(input int max, input int force_after);
        int k = 0;
        while (!m_done && k < max) begin
            force_trig = (force_after >= 0 && k >= force_after);
            tick();
            k++;
        end
        force_trig = 1'b0;
        chk("capture_timeout", m_done, 1);
    endtask

    task automatic readout(input bit rnd);
        int k = 0;
        while (m_done && k < 200) begin
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        rd_ready = 1'b1;
        chk("readout_timeout", m_done, 0);
        chk("xfer_count", m_k, DEPTH);
    endtask

    initial begin
        reset_n = 1'b0; ad_in = '0; div = '0; arm = 1'b0; force_trig = 1'b0;
        trig_ch = '0; trig_level = '0; trig_edge = 1'b0; pretrig = '0; rd_ready = 1'b1;
        ad_mode = 0; ch0_v = '0; ch1_v = '0; ramp_v = '0;
        model_clear();
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        @(negedge clk50m);
        reset_n = 1'b1;
        tick();
        tick();

        // Ramp through 0x800 with four pre-trigger samples
        pretrig = 4'd4; trig_edge = 1'b0; trig_level = 12'h800; trig_ch = 1'b0;
        ad_mode = 1; ramp_v = 12'h7F8; ch1_v = 12'h0;
        pulse_arm();
        run_done(100, -1);
        readout(0);
        chk("ramp_first_word", got[0], 24'h0007FC);
        chk("ramp_trig_word", got[4], 24'h000800);
        chk("ramp_last_word", got[15], 24'h00080B);

        // Decimation by 4
        div = 16'd3;
        do_reset();
        ad_mode = 1; ramp_v = 12'h0E0; pretrig = 4'd2; trig_level = 12'h100;
        pulse_arm();
        run_done(300, -1);
        readout(0);
        for (int i = 0; i < 3; i++) begin
            d = got[i+1][11:0] - got[i][11:0];
            chk("decim_step", d, 4);
        end

        // Falling edge on channel 1, force ignored while idle
        div = 16'd0;
        do_reset();
        ad_mode = 0; ch0_v = 12'h555; ch1_v = 12'hFFF;
        force_trig = 1'b1;
        tick();
        tick();
        force_trig = 1'b0;
        chk("force_idle_busy", busy, 0);
        chk("force_idle_trig", triggered, 0);
        trig_ch = 1'b1; trig_edge = 1'b1; trig_level = 12'h800; pretrig = 4'd0;
        pulse_arm();
        tick();
        ch1_v = 12'h000;
        run_done(50, -1);
        readout(0);
        chk("fall_word0_ch1", got[0][23:12], 0);

        // Random data, random config, random back-pressure
        div = 16'd1;
        do_reset();
        for (int it = 0; it < 3; it++) begin
            ad_mode    = 2;
            pretrig    = (it == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            trig_ch    = 1'($urandom_range(0, 1));
            trig_level = 12'($urandom);
            trig_edge  = 1'($urandom_range(0, 1));
            pulse_arm();
            run_done(300, 60);
            readout(1);
        end

        // Reset during POST and during readout
        div = 16'd0;
        do_reset();
        ad_mode = 1; ramp_v = 12'h100; trig_ch = 1'b0; trig_edge = 1'b0;
        trig_level = 12'h108; pretrig = 4'd4;
        pulse_arm();
        n = 0;
        while (!(m_cap && m_trig >= 0) && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("in_post", {busy, triggered}, 2'b11);
        do_reset();
        repeat (20) tick();
        ramp_v = 12'h100;
        pulse_arm();
        run_done(100, -1);
        n = 0;
        while (m_k < 5 && n < 50) begin
            tick();
            n++;
        end
        chk("reached_word5", m_k, 5);
        do_reset();
        repeat (5) tick();
        ramp_v = 12'h100;
        pulse_arm();
        run_done(100, -1);
        readout(0);

        // Constant trigger channel: waits, ignores re-arm, then forced
        ad_mode = 3; ch0_v = 12'h123; ramp_v = 12'h0; trig_ch = 1'b0; trig_edge = 1'b0;
        trig_level = 12'h800; pretrig = 4'd6;
        pulse_arm();
        for (int i = 0; i < 40; i++) begin
            arm = (i % 7 == 3);
            tick();
        end
        arm = 1'b0;
        chk("still_waiting", {busy, triggered, done}, 3'b100);
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        run_done(50, -1);
        readout(0);
        d = got[6][23:12] - got[5][23:12];
        chk("forced_trig_step", d, 1);

        // Arm during readout restarts the capture
        pretrig = 4'd3;
        pulse_arm();
        force_trig = 1'b1;
        run_done(60, 5);
        tick();
        tick();
        pulse_arm();
        chk("rearm_valid_low", rd_valid, 0);
        run_done(60, 5);
        readout(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
